// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//
// Multi-cycle data memory for the MEM stage of the pipelined MIPS core. It
// accepts one load/store at a time and holds the pipeline with `stall` for
// LATENCY cycles. It then commits the access and pulses `ready` for one cycle,
// which is the cycle in which the pipeline advances.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset (also clears every word)
//   MemRd      load request from the EX/MEM register
//   MemWr      store request from the EX/MEM register
//   Address    byte address; word index is Address[log2(DEPTH_WORDS)+1:2]
//   writeData  store data
//   ReadData   registered load data (holds between accesses)
//   stall      pipeline hold; high for exactly LATENCY cycles per access
//   ready      one-cycle pulse in the cycle the access completes
//   err        sticky misaligned-access flag, cleared only by rst
//
// Parameters
//   DEPTH_WORDS  number of 32-bit words (power of two, >= 2)
//   LATENCY      stall cycles per access (>= 1)
// -----------------------------------------------------------------------------
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRd,
    input  logic        MemWr,
    input  logic [31:0] Address,
    input  logic [31:0] writeData,
    output logic [31:0] ReadData,
    output logic        stall,
    output logic        ready,
    output logic        err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    // The counter only ever holds values up to LATENCY-1.
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    // Request captured on the accepting edge; the pipeline is frozen
    // afterwards, but the live inputs are not trusted once the access starts.
    logic            wr_q;
    logic            mis_q;
    logic [AW-1:0]   idx_q;
    logic [31:0]     wdata_q;

    logic [31:0]     rdata_q;
    logic            err_q;
    logic [31:0]     mem_q [DEPTH_WORDS];

    logic            req;
    logic            accept;
    logic            commit;

    // Fields used on the commit edge. With LATENCY==1 the commit edge is the
    // accepting edge itself, so the live inputs are used there instead of the
    // latched copies (which are not loaded yet).
    logic            c_wr;
    logic            c_mis;
    logic [AW-1:0]   c_idx;
    logic [31:0]     c_wdata;

    // The address bits above the word index only create aliases.
    logic            unused_addr_hi;
    assign unused_addr_hi = ^Address[31:AW+2];

    assign req    = MemRd | MemWr;
    assign accept = (state_q == IDLE) && req;

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        commit  = 1'b0;
        unique case (state_q)
            IDLE: begin
                stall = req;
                if (req) begin
                    cnt_d = CW'(LATENCY - 1);
                    if (LATENCY > 1) begin
                        state_d = BUSY;
                    end else begin
                        state_d = DONE;
                        commit  = 1'b1;
                    end
                end
            end
            BUSY: begin
                stall = 1'b1;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                    commit  = 1'b1;
                end
            end
            DONE: begin
                // The request is still present here, but it belongs to the
                // access that just finished, so it is not accepted again.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        if (state_q == IDLE) begin
            c_wr    = MemWr;
            c_mis   = |Address[1:0];
            c_idx   = Address[AW+1:2];
            c_wdata = writeData;
        end else begin
            c_wr    = wr_q;
            c_mis   = mis_q;
            c_idx   = idx_q;
            c_wdata = wdata_q;
        end
    end

    // -------------------------------------------------------------------------
    // Control and request registers
    // -------------------------------------------------------------------------
    // NOTE: state uses non-blocking assignments so that every register samples
    // pre-edge values, whatever order the blocks are evaluated in.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            mis_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                wr_q    <= MemWr;
                mis_q   <= |Address[1:0];
                idx_q   <= Address[AW+1:2];
                wdata_q <= writeData;
            end
            if (commit) begin
                // Every aligned access returns the pre-write word, which gives
                // read-before-write when MemRd and MemWr are both set.
                rdata_q <= c_mis ? 32'h0 : mem_q[c_idx];
                err_q   <= err_q | c_mis;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Storage
    // -------------------------------------------------------------------------
    // NOTE: the array is cleared on reset because software relies on
    // zero-initialised data memory. That prevents mapping it onto a RAM macro,
    // which is acceptable for this slow-memory timing model.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (commit && c_wr && !c_mis) begin
            mem_q[c_idx] <= c_wdata;
        end
    end

    assign ReadData = rdata_q;
    assign ready    = (state_q == DONE);
    assign err      = err_q;

endmodule
